uart_tx_drv: RTL and testbench
==============================

UART_TX_DRV -- requirements
Module: uart_tx_drv

Interface
REQ-001 Parameter FCPU, default 3072000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 19200, line bit rate.
REQ-003 Parameter FIFO_DEPTH, default 4, byte queue entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_b  input  1  reset, synchronous and active-low.
REQ-006 tx_data  input  8  byte to transmit.
REQ-007 tx_valid  input  1  tx_data is offered this cycle.
REQ-008 tx_ready  output  1  a byte offered this cycle is accepted.
REQ-009 sout  output  1  serial line, idle high, 8N1, LSB first.
REQ-010 busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-011 fifo_cnt  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

Function
REQ-012 Constant CYCLE_CNT = FCPU/(BAUD*16) - 1, integer division; this sets the 16x oversample rate.
REQ-013 Divider: 32-bit down-counter, loads CYCLE_CNT at reset and whenever it reaches 0, otherwise decrements; tick = 1 for the one cycle the counter is 0.
REQ-014 The divider free-runs and is never resynchronised to traffic.
REQ-015 tx_ready = (fifo_cnt != FIFO_DEPTH), driven combinationally from registered state only.
REQ-016 Push on tx_valid && tx_ready: write at the write pointer, increment it, modulo FIFO_DEPTH.
REQ-017 Pop only in IDLE, on a tick, when fifo_cnt != 0: load the shift register, advance the read pointer.
REQ-018 Push and pop in the same cycle: both occur and fifo_cnt is unchanged.
REQ-019 Pop when full frees a slot; tx_ready rises on the next cycle, not combinationally.
REQ-020 FSM states IDLE, START, DATA, STOP; a 4-bit tick counter and a 3-bit bit index hold the position.
REQ-021 IDLE: sout = 1; a pop moves to START with the tick counter at 0.
REQ-022 START: sout = 0 for 16 ticks, then DATA with bit index 0.
REQ-023 DATA: sout = shift[bit index] for 16 ticks per bit; after bit 7 completes, go to STOP.
REQ-024 STOP: sout = 1 for 16 ticks; then go to START directly if the FIFO is non-empty (popping on that tick), else IDLE.
REQ-025 Back-to-back frames have exactly one stop bit; no extra idle time is inserted.
REQ-026 sout is a flop output (glitch-free); it changes one cycle after the tick that causes the transition.
REQ-027 Each bit lasts 16*(CYCLE_CNT+1) clocks; a frame lasts 160*(CYCLE_CNT+1) clocks.
REQ-028 busy = (state != IDLE) || (fifo_cnt != 0).
REQ-029 tx_data is ignored when tx_valid is low, and when tx_valid is high with tx_ready low (no write, no error).

Reset
REQ-030 rst_b low at a clock edge sets: state IDLE, sout 1, fifo_cnt 0, both pointers 0, divider CYCLE_CNT, tick and bit counters 0.
REQ-031 Reset output values: tx_ready 1, busy 0.
REQ-032 Reset during a frame aborts it: sout is 1 from the next edge, and queued bytes are discarded.
REQ-033 FIFO storage contents are not reset.

Structure
REQ-034 Shared package uart_pkg holds the FSM state enum, the oversample factor (16) and the frame length (10 bits), for reuse by the UART monitor.
REQ-035 The FIFO is one sub-module, uart_tx_fifo: push/pop, count, full/empty, parameterised by depth.

Verification
REQ-036 Default parameters, push 0x41 once -> sout low 160 clocks, then bits 1,0,0,0,0,0,1,0 at 160 clocks each, then high; the UART monitor prints 'A'.
REQ-037 Push 0x55, 0xAA, 0x0F, 0xF0 in 4 consecutive cycles -> tx_ready stays 1, fifo_cnt reaches 3 or 4, frames are contiguous (4x1600 clocks, one stop bit each), and the bytes arrive in order.
REQ-038 Hold tx_valid high with 6 bytes -> tx_ready drops when fifo_cnt = 4; the 6th byte is accepted only after a pop; no byte is lost or duplicated.
REQ-039 Push and pop in the same cycle with fifo_cnt = 2 -> fifo_cnt stays 2.
REQ-040 Assert rst_b = 0 for 1 cycle mid-DATA with 2 bytes queued -> sout = 1 next cycle, fifo_cnt = 0, busy = 0, no further frame starts.
REQ-041 FCPU = 6144000 -> bit period 320 clocks; the monitor instantiated with the same clock decodes 0x7E correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, oversample factor and frame length.
// Also used by the UART monitor.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  // Divider reload value for a 16x oversample tick.
  function automatic logic [31:0] cycle_cnt(input int unsigned fcpu, input int unsigned baud);
    return 32'(fcpu / (baud * OVERSAMPLE) - 32'd1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue for the UART transmitter.
// Push and pop may occur in the same cycle. Storage is not reset.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);

endmodule

// File: rtl/uart_tx_drv.sv
// Buffered 8N1 UART transmitter.
// A free-running 16x tick divider paces the shift FSM.
module uart_tx_drv
  import uart_pkg::*;
#(
  parameter  int unsigned FCPU       = 3072000,
  parameter  int unsigned BAUD       = 19200,
  parameter  int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sout,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_cnt
);

  localparam logic [31:0] CYCLE_CNT = cycle_cnt(FCPU, BAUD);
  localparam logic [3:0]  LAST_TICK = 4'(OVERSAMPLE - 1);

  logic [31:0] div_q;
  logic        tick;
  tx_state_e   state_q, state_n;
  logic [3:0]  tick_q, tick_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  shift_q, shift_n;
  logic        sout_q, sout_n;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_data;

  // Oversample divider; never resynchronised to traffic.
  always_ff @(posedge clk) begin
    if (!rst_b)    div_q <= CYCLE_CNT;
    else if (tick) div_q <= CYCLE_CNT;
    else           div_q <= div_q - 32'd1;
  end

  assign tick     = (div_q == '0);
  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (push),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .cnt       (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      sout_q  <= sout_n;
    end
  end

  // Frame sequencing; sout is registered from the next-state view.
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    pop     = 1'b0;
    sout_n  = 1'b1;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_data;
            tick_n  = '0;
            state_n = START;
          end
        end
        START: begin
          tick_n = tick_q + 4'd1;
          if (tick_q == LAST_TICK) begin
            bit_n   = '0;
            state_n = DATA;
          end
        end
        DATA: begin
          tick_n = tick_q + 4'd1;
          if (tick_q == LAST_TICK) begin
            if (bit_q == 3'd7) state_n = STOP;
            else               bit_n   = bit_q + 3'd1;
          end
        end
        STOP: begin
          tick_n = tick_q + 4'd1;
          if (tick_q == LAST_TICK) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_n = fifo_data;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    case (state_n)
      START:   sout_n = 1'b0;
      DATA:    sout_n = shift_n[bit_n];
      default: sout_n = 1'b1;
    endcase
  end

  assign sout = sout_q;
  assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_drv.sv
// Directed bench for uart_tx_drv: framing, FIFO flow control, reset abort,
// and a second instance at double clock rate.
`timescale 1ns/1ps
module tb_uart_tx_drv;

  localparam int BIT1 = 160;
  localparam int BIT2 = 320;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_ready2;
  logic       sout, sout2;
  logic       busy, busy2;
  logic [2:0] fifo_cnt, fifo_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_drv dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sout     (sout),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  uart_tx_drv #(.FCPU(6144000)) dut2 (
    .clk      (clk),
    .rst_b    (rst_b),
    .tx_data  (tx_data2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2),
    .sout     (sout2),
    .busy     (busy2),
    .fifo_cnt (fifo_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then samples every cycle of the frame.
  task automatic rx_frame(input bit sel, input int period, output logic [7:0] data,
                          output int gap, output bit ok);
    logic [9:0] bits;
    logic       s;
    bit         stable;
    gap  = 0;
    data = '0;
    ok   = 1'b0;
    do begin
      @(negedge clk);
      gap++;
      s = sel ? sout2 : sout;
    end while (s !== 1'b0 && gap < 20000);
    if (s !== 1'b0) begin
      check("rx_start_timeout", 32'(s), 32'd0);
      return;
    end
    stable = 1'b1;
    bits   = '0;
    for (int i = 0; i < 10 * period; i++) begin
      if (i > 0) begin
        @(negedge clk);
        s = sel ? sout2 : sout;
      end
      if (i % period == 0) bits[i / period] = s;
      else if (s !== bits[i / period]) stable = 1'b0;
    end
    data = bits[8:1];
    ok   = stable && (bits[0] == 1'b0) && (bits[9] == 1'b1);
  endtask

  task automatic wait_low(output bit found);
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (sout === 1'b0) found = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         gap;
    bit         ok;
    bit         found;
    logic [7:0] b4 [4];
    logic [7:0] b6 [6];
    int         maxc;
    int         lows;

    b4 = '{8'h55, 8'hAA, 8'h0F, 8'hF0};
    b6 = '{8'h31, 8'hC2, 8'h5A, 8'hE7, 8'h08, 8'h9D};

    rst_b = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    repeat (3) @(negedge clk);
    check("rst_sout", 32'(sout), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    rst_b = 1'b1;

    // Single byte 'A'
    @(negedge clk);
    tx_data = 8'h41; tx_valid = 1'b1;
    check("t1_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1_busy", 32'(busy), 32'd1);
    rx_frame(1'b0, BIT1, d, gap, ok);
    check("t1_data", 32'(d), 32'h41);
    check("t1_frame", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_sout", 32'(sout), 32'd1);

    // Four bytes in consecutive cycles
    maxc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
          tx_data = b4[i]; tx_valid = 1'b1;
          check("t2_ready", 32'(tx_ready), 32'd1);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        if (int'(fifo_cnt) > maxc) maxc = int'(fifo_cnt);
        check("t2_maxcnt_ge3", 32'(maxc >= 3), 32'd1);
      end
      begin
        logic [7:0] rd;
        int         rg;
        bit         rok;
        for (int f = 0; f < 4; f++) begin
          rx_frame(1'b0, BIT1, rd, rg, rok);
          check($sformatf("t2_data%0d", f), 32'(rd), 32'(b4[f]));
          check($sformatf("t2_frame%0d", f), 32'(rok), 32'd1);
          if (f > 0) check($sformatf("t2_gap%0d", f), 32'(rg), 32'd1);
        end
      end
    join
    wait_idle("t2_idle");

    // Six bytes with tx_valid held high
    fork
      begin
        int  i;
        int  cyc;
        bit  seen_drop;
        i = 0; cyc = 0; seen_drop = 1'b0;
        while (i < 6 && cyc < 8000) begin
          @(negedge clk);
          cyc++;
          tx_data = b6[i]; tx_valid = 1'b1;
          if (!tx_ready && !seen_drop) begin
            seen_drop = 1'b1;
            check("t3_drop_cnt", 32'(fifo_cnt), 32'd4);
          end
          if (tx_ready) i++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("t3_pushed", 32'(i), 32'd6);
        check("t3_dropped", 32'(seen_drop), 32'd1);
      end
      begin
        logic [7:0] rd;
        int         rg;
        bit         rok;
        for (int f = 0; f < 6; f++) begin
          rx_frame(1'b0, BIT1, rd, rg, rok);
          check($sformatf("t3_data%0d", f), 32'(rd), 32'(b6[f]));
          check($sformatf("t3_frame%0d", f), 32'(rok), 32'd1);
          if (f > 0) check($sformatf("t3_gap%0d", f), 32'(rg), 32'd1);
        end
      end
    join
    wait_idle("t3_idle");

    // Push coinciding with the back-to-back pop at frame end, fifo_cnt = 2
    @(negedge clk);
    tx_data = 8'hA1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_low(found);
    check("t4_start", 32'(found), 32'd1);
    @(negedge clk); tx_data = 8'hA2; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'hA3;
    @(negedge clk); tx_valid = 1'b0;
    repeat (1596) @(negedge clk);
    check("t4_cnt_before", 32'(fifo_cnt), 32'd2);
    tx_data = 8'hA4; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4_cnt_after", 32'(fifo_cnt), 32'd2);
    check("t4_next_start", 32'(sout), 32'd0);
    wait_idle("t4_idle");

    // Reset in the middle of a data bit with two bytes queued
    @(negedge clk);
    tx_data = 8'hB1; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_low(found);
    check("t5_start", 32'(found), 32'd1);
    @(negedge clk); tx_data = 8'hB2; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'hB3;
    @(negedge clk); tx_valid = 1'b0;
    repeat (400) @(negedge clk);
    check("t5_cnt_pre", 32'(fifo_cnt), 32'd2);
    check("t5_busy_pre", 32'(busy), 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check("t5_sout", 32'(sout), 32'd1);
    check("t5_cnt", 32'(fifo_cnt), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(tx_ready), 32'd1);
    lows = 0;
    repeat (3400) begin
      @(negedge clk);
      if (sout !== 1'b1) lows++;
    end
    check("t5_quiet", 32'(lows), 32'd0);
    check("t5_busy_post", 32'(busy), 32'd0);

    // Double clock rate instance: 320-clock bits
    @(negedge clk);
    tx_data2 = 8'h7E; tx_valid2 = 1'b1;
    @(negedge clk);
    tx_valid2 = 1'b0;
    rx_frame(1'b1, BIT2, d, gap, ok);
    check("t6_data", 32'(d), 32'h7E);
    check("t6_frame", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    check("t6_idle", 32'(busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
